// File: rtl/prra_grant_ctrl.sv
// Registered pseudo round-robin grant controller: samples a request vector, holds a
// one-hot grant until the requester drops or the optional hold limit expires.
module prra_grant_ctrl #(
   parameter int WIDTH      = 4,
   parameter int LOG2_WIDTH = 2,
   parameter int MAX_HOLD   = 0,
   parameter int HOLD_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      request,
   output logic [WIDTH-1:0]      grant,
   output logic [LOG2_WIDTH-1:0] grant_idx,
   output logic                  grant_valid,
   output logic                  timeout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   localparam logic                  TIMEOUT_EN = (MAX_HOLD != 0);
   localparam logic [HOLD_WIDTH-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : HOLD_WIDTH'(MAX_HOLD - 1);
   localparam logic [LOG2_WIDTH-1:0] LAST_RST   = LOG2_WIDTH'(WIDTH - 1);
   localparam logic [WIDTH-1:0]      ONE        = WIDTH'(1);

   // First set request bit scanning upward from last+1 with wrap-around.
   function automatic logic [LOG2_WIDTH-1:0] rr_pick(input logic [WIDTH-1:0]      req,
                                                     input logic [LOG2_WIDTH-1:0] last);
      logic [LOG2_WIDTH-1:0] win;
      logic [LOG2_WIDTH-1:0] cand;
      logic                  found;
      win   = '0;
      found = 1'b0;
      for (int i = 1; i <= WIDTH; i++) begin
         cand = LOG2_WIDTH'((int'(last) + i) % WIDTH);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      return win;
   endfunction

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        grant_q, grant_d;
   logic [LOG2_WIDTH-1:0]   grant_idx_q, grant_idx_d;
   logic                    grant_valid_q, grant_valid_d;
   logic                    timeout_q, timeout_d;
   logic [HOLD_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
   logic [LOG2_WIDTH-1:0]   last_q, last_d;
   logic [LOG2_WIDTH-1:0]   winner;

   assign winner = rr_pick(request, last_q);

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      timeout_d     = 1'b0;
      hold_cnt_d    = hold_cnt_q;
      last_d        = last_q;
      case (state_q)
         S_IDLE: begin
            if (|request) begin
               state_d       = S_GRANT;
               grant_d       = ONE << winner;
               grant_idx_d   = winner;
               grant_valid_d = 1'b1;
               last_d        = winner;
               hold_cnt_d    = '0;
            end
         end
         S_GRANT: begin
            // A drop takes precedence, so a coincident hold expiry never pulses timeout.
            if (!request[grant_idx_q]) begin
               state_d       = S_RELEASE;
               grant_d       = '0;
               grant_idx_d   = '0;
               grant_valid_d = 1'b0;
            end else if (TIMEOUT_EN && (hold_cnt_q == HOLD_LAST)) begin
               state_d       = S_RELEASE;
               grant_d       = '0;
               grant_idx_d   = '0;
               grant_valid_d = 1'b0;
               timeout_d     = 1'b1;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d    = hold_cnt_q + 1'b1;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d       = S_IDLE;
            grant_d       = '0;
            grant_idx_d   = '0;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
         hold_cnt_q    <= '0;
         last_q        <= LAST_RST;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         timeout_q     <= timeout_d;
         hold_cnt_q    <= hold_cnt_d;
         last_q        <= last_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_prra_grant_ctrl.sv
// Bench for prra_grant_ctrl: hand-computed vector table, corner sequences, and a
// randomized run against an abstract round-robin model; two instances (no timeout, MAX_HOLD=4).
module tb_prra_grant_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req0 = 4'b0000;
   logic [3:0] req4 = 4'b0000;
   logic [3:0] g0, g4;
   logic [1:0] i0, i4;
   logic       v0, v4, t0, t4;

   always #5 clk = ~clk;

   prra_grant_ctrl #(.WIDTH(4), .LOG2_WIDTH(2), .MAX_HOLD(0), .HOLD_WIDTH(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .request(req0),
      .grant(g0), .grant_idx(i0), .grant_valid(v0), .timeout(t0));

   prra_grant_ctrl #(.WIDTH(4), .LOG2_WIDTH(2), .MAX_HOLD(4), .HOLD_WIDTH(8)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .request(req4),
      .grant(g4), .grant_idx(i4), .grant_valid(v4), .timeout(t4));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit         rst;
      int         sel;
      logic [3:0] req;
      logic [3:0] eg;
      logic [1:0] ei;
      logic       ev;
      logic       et;
   } vec_t;

   vec_t vecs[$];

   int   m_owner[2];
   int   m_held[2];
   int   m_cool[2];
   int   m_last[2];
   logic m_to[2];
   int   m_max[2] = '{0, 4};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input string tag, input int sel, input logic [3:0] eg,
                            input logic [1:0] ei, input logic ev, input logic et);
      logic [3:0] g;
      logic [1:0] i;
      logic       v, t;
      if (sel == 0) begin g = g0; i = i0; v = v0; t = t0; end
      else          begin g = g4; i = i4; v = v4; t = t4; end
      chk({tag, ".grant"},       32'(g), 32'(eg));
      chk({tag, ".grant_idx"},   32'(i), 32'(ei));
      chk({tag, ".grant_valid"}, 32'(v), 32'(ev));
      chk({tag, ".timeout"},     32'(t), 32'(et));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0  = 4'b0000;
      req4  = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic add(input bit r, input int s, input logic [3:0] q, input logic [3:0] eg,
                      input logic [1:0] ei, input logic ev, input logic et);
      vec_t v;
      v.rst = r; v.sel = s; v.req = q; v.eg = eg; v.ei = ei; v.ev = ev; v.et = et;
      vecs.push_back(v);
   endtask

   // Abstract model: owner (-1 = none), cycles held, dead cycles left, last winner.
   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_owner[s] = -1;
         m_held[s]  = 0;
         m_cool[s]  = 0;
         m_last[s]  = 3;
         m_to[s]    = 1'b0;
      end
   endtask

   task automatic model_step(input int s, input logic [3:0] r);
      int o;
      int c;
      bit found;
      m_to[s] = 1'b0;
      o = m_owner[s];
      if (o >= 0) begin
         if (r[o[1:0]] == 1'b0) begin
            m_owner[s] = -1;
            m_cool[s]  = 1;
         end else if (m_max[s] != 0 && m_held[s] + 1 == m_max[s]) begin
            m_owner[s] = -1;
            m_cool[s]  = 1;
            m_to[s]    = 1'b1;
         end else begin
            m_held[s]++;
         end
      end else if (m_cool[s] > 0) begin
         m_cool[s]--;
      end else if (r != 4'b0000) begin
         found = 1'b0;
         for (int d = 1; d <= 4; d++) begin
            c = (m_last[s] + d) % 4;
            if (!found && r[c[1:0]]) begin
               found      = 1'b1;
               m_owner[s] = c;
               m_last[s]  = c;
               m_held[s]  = 0;
            end
         end
      end
   endtask

   task automatic model_check(input string tag, input int s);
      logic [3:0] eg;
      logic [1:0] ei;
      logic       ev;
      ev = (m_owner[s] >= 0);
      eg = ev ? 4'(1 << m_owner[s]) : 4'b0000;
      ei = ev ? 2'(m_owner[s]) : 2'd0;
      check_dut(tag, s, eg, ei, ev, m_to[s]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] drop;
      int         w;

      // Idle with no requests after reset.
      for (int k = 0; k < 10; k++) add(1'b0, 0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      // All four requesting, each winner holds three cycles then drops and reasserts.
      for (int k = 0; k < 5; k++) begin
         w    = k % 4;
         drop = 4'b1111 & ~4'(1 << w);
         for (int h = 0; h < 3; h++) add(1'b0, 0, 4'b1111, 4'(1 << w), 2'(w), 1'b1, 1'b0);
         add(1'b0, 0, drop,    4'b0000, 2'd0, 1'b0, 1'b0);
         add(1'b0, 0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
      end
      // 1010 from reset, one-cycle grants alternate 1,3,1,3.
      add(1'b1, 0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
      add(1'b0, 0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
      add(1'b0, 0, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);
      add(1'b0, 0, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0);
      add(1'b0, 0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0);
      add(1'b0, 0, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);
      add(1'b0, 0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
      add(1'b0, 0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
      add(1'b0, 0, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);
      add(1'b0, 0, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0);
      // MAX_HOLD=4, sole requester 0: 4 grant cycles, timeout, dead cycle, regrant.
      for (int p = 0; p < 2; p++) begin
         add(p == 0, 1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
         for (int h = 0; h < 3; h++) add(1'b0, 1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
         add(1'b0, 1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1);
         add(1'b0, 1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
      end
      add(1'b0, 1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
      // MAX_HOLD=4, requester 2 holding while 1 also requests: 1 wins after timeout.
      add(1'b1, 1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
      for (int h = 0; h < 3; h++) add(1'b0, 1, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0);
      add(1'b0, 1, 4'b0110, 4'b0000, 2'd0, 1'b0, 1'b1);
      add(1'b0, 1, 4'b0110, 4'b0000, 2'd0, 1'b0, 1'b0);
      add(1'b0, 1, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0);
      for (int h = 0; h < 3; h++) add(1'b0, 1, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0);
      add(1'b0, 1, 4'b0110, 4'b0000, 2'd0, 1'b0, 1'b1);
      add(1'b0, 1, 4'b0110, 4'b0000, 2'd0, 1'b0, 1'b0);
      add(1'b0, 1, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0);
      // Drop on the same edge the hold limit expires: plain release, no timeout pulse.
      add(1'b1, 1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
      for (int h = 0; h < 3; h++) add(1'b0, 1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
      for (int h = 0; h < 3; h++) add(1'b0, 1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

      do_reset();
      check_dut("reset.dut0", 0, 4'b0000, 2'd0, 1'b0, 1'b0);
      check_dut("reset.dut4", 1, 4'b0000, 2'd0, 1'b0, 1'b0);

      foreach (vecs[k]) begin
         if (vecs[k].rst) do_reset();
         if (vecs[k].sel == 0) req0 = vecs[k].req;
         else                  req4 = vecs[k].req;
         step();
         check_dut($sformatf("vec%0d", k), vecs[k].sel, vecs[k].eg, vecs[k].ei,
                   vecs[k].ev, vecs[k].et);
      end

      // Asynchronous reset in the middle of a grant on requester 2.
      do_reset();
      req0 = 4'b0100;
      step();
      check_dut("async.pre", 0, 4'b0100, 2'd2, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      check_dut("async.rst", 0, 4'b0000, 2'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
      req0  = 4'b0111;
      step();
      check_dut("async.post", 0, 4'b0001, 2'd0, 1'b1, 1'b0);

      // Pointer must return to WIDTH-1: after a grant to 0, reset, then 0011 picks 0.
      do_reset();
      req4 = 4'b0001;
      step();
      check_dut("ptr.pre", 1, 4'b0001, 2'd0, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      check_dut("ptr.rst", 1, 4'b0000, 2'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
      req4  = 4'b0011;
      step();
      check_dut("ptr.post", 1, 4'b0001, 2'd0, 1'b1, 1'b0);

      // Randomized run against the model on both instances.
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (cyc == 1000) begin
            do_reset();
            model_reset();
         end
         if ($urandom_range(0, 3) == 0) req0 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) req4 = 4'($urandom_range(0, 15));
         step();
         model_step(0, req0);
         model_step(1, req4);
         model_check($sformatf("rnd%0d.dut0", cyc), 0);
         model_check($sformatf("rnd%0d.dut4", cyc), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prra_grant_ctrl.md
Name: prra_grant_ctrl

Overview:
- Registered pseudo round-robin arbiter. It is the stateful consumer side of the combinational PRRA request-to-index LUT.
- Samples a request vector, issues a held one-hot grant plus its index, and tracks the round-robin pointer across grants.
- Releases a grant on requester drop or on a hold-timeout. Used at HyNoC router output ports to allocate a port to one input channel.

Parameters:
- WIDTH, 4, number of requesters (>=2).
- LOG2_WIDTH, 2, width of grant index; must equal ceil(log2(WIDTH)).
- MAX_HOLD, 0, maximum grant duration in cycles; 0 disables the timeout.
- HOLD_WIDTH, 8, width of the hold counter; MAX_HOLD < 2**HOLD_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- request  in  WIDTH  per-requester request, level, held until served.
- grant  out  WIDTH  registered one-hot grant, all-zero when idle.
- grant_idx  out  LOG2_WIDTH  registered index of granted requester, 0 when idle.
- grant_valid  out  1  registered, high while a grant is held.
- timeout  out  1  registered single-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async assert, sync deassert by user): grant=0, grant_idx=0, grant_valid=0, timeout=0, FSM=IDLE, hold counter=0, pointer last=WIDTH-1. First priority therefore goes to requester 0.
- FSM states: IDLE, GRANT, RELEASE.
- Priority function: first set bit of request scanning (last+1) mod WIDTH upward with wrap. This equals the PRRA LUT lookup with offset last+1.
- IDLE:
  - If request != 0 at a rising edge, go to GRANT.
  - At that edge load grant/grant_idx from the priority function, set grant_valid=1, set last=winner, clear the hold counter.
  - One-cycle latency from request to grant.
- GRANT, each edge:
  - If request[grant_idx]==0: go to RELEASE; clear grant, grant_idx and grant_valid.
  - Else if MAX_HOLD!=0 and counter==MAX_HOLD-1: go to RELEASE; clear the grant; pulse timeout=1 for one cycle.
  - Else: increment the counter (saturating); hold the grant unchanged.
  - Other requesters' bits are ignored while in GRANT.
- RELEASE: one mandatory dead cycle with outputs idle; timeout returns to 0. Next edge goes to IDLE. No arbitration occurs in RELEASE.
- Minimum grant-to-grant spacing:
  - Requester drop: grant drops at edge E, RELEASE occupies E to E+1, IDLE arbitrates at E+2, new grant visible after E+2.
  - Throughput bound: one grant per 3 cycles when each grant lasts 1 cycle.
- Timeout revocation: the revoked requester keeps its request. Because last=its index, it gets lowest priority next round, so other requesters win first. It is regranted only if it is the sole requester.
- Simultaneous events: the request drop and the timeout on the same edge resolve as a normal drop (timeout stays 0).
- X/unknown request bits are not supported; the bench drives known values only.
- Mid-operation reset: all outputs clear immediately on rst_n low, independent of clk. The pointer returns to WIDTH-1.
- Invariants:
  - grant is one-hot or zero.
  - grant_valid == (grant != 0).
  - grant == 1<<grant_idx when valid.
- Pure RTL, no vendor primitives. The priority function is a combinational loop or generated LUT inside the block.

Test Plan:
- Reset then request=4'b0000 for 10 cycles -> grant=0, grant_valid=0, grant_idx=0, timeout=0 throughout.
- request=4'b1111 held, each winner drops its bit 3 cycles after grant, then reasserts -> grant_idx sequence 0,1,2,3,0 with 1 RELEASE cycle between grants.
- request=4'b1010 from reset, winner drops after 1 cycle then reasserts -> grant_idx 1,3,1,3; grant 4'b0010, 4'b1000 alternating.
- MAX_HOLD=4, request=4'b0001 held constant -> grant_valid high exactly 4 cycles, timeout pulse on the drop edge, RELEASE, regrant to 0; period 6 cycles.
- MAX_HOLD=4, requester 2 granted and holding while request=4'b0110 -> after timeout, next grant_idx=1 (not 2).
- rst_n pulsed low mid-GRANT with grant_idx=2 -> outputs 0 asynchronously. With request=4'b0111 after release, the next grant is idx 0.
